// File: rtl/apb_screen_pkg.sv
// Shared register map, bit positions and CTRL layout for the APB screen TX FIFO.
package apb_screen_pkg;

    localparam logic [1:0] ADDR_TXDATA = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_THRESH = 2'd3;

    localparam int STAT_EMPTY     = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_OVF       = 2;
    localparam int STAT_IRQ       = 3;
    localparam int STAT_LEVEL_LSB = 8;

    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_FLUSH  = 1;
    localparam int CTRL_IRQ_EN = 2;

    typedef struct packed {
        logic irq_en;
        logic flush;
        logic enable;
    } ctrl_t;

    // flush is a one-shot command, so it is never retained in the stored register.
    function automatic ctrl_t ctrl_from_word(input logic [31:0] word);
        ctrl_t c;
        c.irq_en = word[CTRL_IRQ_EN];
        c.flush  = 1'b0;
        c.enable = word[CTRL_ENABLE];
        return c;
    endfunction

endpackage

// File: rtl/apb_screen_txfifo_fifo.sv
// Single-clock FIFO with flush; occupancy counter gives full/empty/level directly.
module screen_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  logic [WIDTH-1:0]         i_din,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_empty;
    logic             w_full;
    logic             w_pop_ok;
    logic             w_push_ok;

    assign w_empty   = (r_level == (AW+1)'(0));
    assign w_full    = (r_level == (AW+1)'(DEPTH));
    // A push into a full FIFO is still legal when the head leaves in the same cycle.
    assign w_pop_ok  = i_pop & ~w_empty & ~i_flush;
    assign w_push_ok = i_push & ~i_flush & (~w_full | w_pop_ok);

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_empty = w_empty;
    assign o_full  = w_full;
    assign o_level = r_level;

    // Storage array; contents are don't-care while the FIFO is empty.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= AW'(0);
            r_rd_ptr <= AW'(0);
            r_level  <= (AW+1)'(0);
        end else if (i_flush) begin
            r_wr_ptr <= AW'(0);
            r_rd_ptr <= AW'(0);
            r_level  <= (AW+1)'(0);
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/apb_screen_txfifo.sv
// APB3 completer buffering screen words into a FIFO that drains over a valid/ready stream.
module apb_screen_txfifo
    import apb_screen_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic        PCLK,
    input  logic        PRESERN,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [7:0]  PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        irq
);

    localparam int         LW   = $clog2(DEPTH) + 1;
    localparam logic [2:0] WS_C = 3'(WAIT_STATES);

    logic [2:0]    r_wait_cnt;
    ctrl_t         r_ctrl;
    logic [LW-1:0] r_thresh;
    logic          r_overflow;
    logic          r_irq;

    logic          w_access;
    logic          w_complete;
    logic          w_wr;
    logic          w_rd;
    logic [1:0]    w_addr;
    logic          w_wr_tx;
    logic          w_flush;
    logic          w_out_valid;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic          w_empty;
    logic          w_full;
    logic [LW-1:0] w_level;
    logic [31:0]   w_fifo_dout;
    logic [31:0]   w_status;
    logic [31:0]   w_rdata;
    logic          w_unused;

    assign w_access   = PSEL & PENABLE;
    assign w_complete = w_access & (r_wait_cnt == WS_C);
    assign w_addr     = PADDR[3:2];
    assign w_wr       = w_complete & PWRITE;
    assign w_rd       = PSEL & ~PWRITE;
    assign w_unused   = ^{PADDR[7:4], PADDR[1:0]};

    assign w_wr_tx     = w_wr & (w_addr == ADDR_TXDATA);
    assign w_flush     = w_wr & (w_addr == ADDR_CTRL) & PWDATA[CTRL_FLUSH];
    assign w_out_valid = r_ctrl.enable & ~w_empty;
    // Flush wins over a same-cycle pop so the head word is discarded, not delivered.
    assign w_pop       = w_out_valid & out_ready & ~w_flush;
    assign w_push      = w_wr_tx & (~w_full | w_pop);
    assign w_drop      = w_wr_tx & w_full & ~w_pop;

    assign PREADY    = w_complete;
    assign PSLVERR   = w_drop;
    assign PRDATA    = w_rdata;
    assign out_data  = w_fifo_dout;
    assign out_valid = w_out_valid;
    assign irq       = r_irq;

    screen_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .i_clk   (PCLK),
        .i_rst_n (PRESERN),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_din   (PWDATA),
        .o_dout  (w_fifo_dout),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_level (w_level)
    );

    // Wait-state counter: advances through the access phase, restarts per transfer.
    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            r_wait_cnt <= 3'd0;
        end else if (!PSEL || w_complete) begin
            r_wait_cnt <= 3'd0;
        end else if (w_access && (r_wait_cnt < WS_C)) begin
            r_wait_cnt <= r_wait_cnt + 3'd1;
        end else begin
            r_wait_cnt <= r_wait_cnt;
        end
    end

    // STATUS word assembly.
    always_comb begin
        w_status                           = 32'd0;
        w_status[STAT_EMPTY]               = w_empty;
        w_status[STAT_FULL]                = w_full;
        w_status[STAT_OVF]                 = r_overflow;
        w_status[STAT_IRQ]                 = r_irq;
        w_status[STAT_LEVEL_LSB +: LW]     = w_level;
    end

    // Read data mux; zero for anything that is not a read.
    always_comb begin
        w_rdata = 32'd0;
        if (w_rd) begin
            case (w_addr)
                ADDR_STATUS: w_rdata = w_status;
                ADDR_CTRL:   w_rdata = {29'd0, r_ctrl};
                ADDR_THRESH: w_rdata = 32'(r_thresh);
                default:     w_rdata = 32'd0;
            endcase
        end else begin
            w_rdata = 32'd0;
        end
    end

    // Control/threshold registers, sticky overflow and the level interrupt.
    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            r_ctrl     <= '0;
            r_thresh   <= '0;
            r_overflow <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            if (w_wr && (w_addr == ADDR_CTRL)) begin
                r_ctrl <= ctrl_from_word(PWDATA);
            end
            if (w_wr && (w_addr == ADDR_THRESH)) begin
                r_thresh <= PWDATA[LW-1:0];
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (w_wr && (w_addr == ADDR_STATUS) && PWDATA[STAT_OVF]) begin
                r_overflow <= 1'b0;
            end
            r_irq <= r_ctrl.irq_en & r_ctrl.enable & (w_level <= r_thresh);
        end
    end

endmodule

// File: tb/tb_apb_screen_txfifo.sv
// Scoreboard bench for apb_screen_txfifo (DEPTH=16, WAIT_STATES=2).
module tb_apb_screen_txfifo;

    localparam int DEPTH = 16;
    localparam int WS    = 2;

    logic        PCLK = 1'b0;
    logic        PRESERN;
    logic        PSEL, PENABLE, PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA, PRDATA;
    logic        PREADY, PSLVERR;
    logic [31:0] out_data;
    logic        out_valid, out_ready, irq;

    int n_checks = 0;
    int n_errors = 0;
    int n_pops   = 0;
    logic [31:0] sb_q [$];
    bit m_enable = 1'b0;

    apb_screen_txfifo #(.DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
        .PCLK(PCLK), .PRESERN(PRESERN), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .irq(irq)
    );

    always #5 PCLK = ~PCLK;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Stream monitor: a handshake seen mid-cycle is consumed at the next rising edge.
    always @(negedge PCLK) begin
        if (PRESERN && out_valid && out_ready) begin
            n_pops++;
            if (sb_q.size() == 0) begin
                check_val("pop_model_empty", 32'(sb_q.size()), 32'd1);
            end else begin
                check_val("out_data", out_data, sb_q.pop_front());
            end
        end
    end

    task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                            input bit pop_at_done, output logic [31:0] rdata,
                            output logic slverr, output int waits);
        waits = 0;
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        while (PREADY !== 1'b1 && waits < 20) begin
            @(posedge PCLK); #1;
            waits++;
        end
        if (PREADY !== 1'b1) check_val("pready_timeout", {31'd0, PREADY}, 32'd1);
        if (pop_at_done) out_ready = 1'b1;
        #1;
        rdata  = PRDATA;
        slverr = PSLVERR;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        if (pop_at_done) out_ready = 1'b0;
    endtask

    task automatic reg_write(input logic [7:0] addr, input logic [31:0] d);
        logic [31:0] rd; logic err; int w;
        apb_xfer(1'b1, addr, d, 1'b0, rd, err, w);
        check_val("reg_wr_err", {31'd0, err}, 32'd0);
        if (addr[3:2] == 2'd2) m_enable = d[0];
    endtask

    task automatic reg_read(input logic [7:0] addr, output logic [31:0] d);
        logic err; int w;
        apb_xfer(1'b0, addr, 32'd0, 1'b0, d, err, w);
    endtask

    task automatic wr_txdata(input logic [31:0] d, input bit pop_at_done);
        logic [31:0] rd; logic err; int w; bit accept;
        accept = (sb_q.size() < DEPTH) || (pop_at_done && m_enable && sb_q.size() > 0);
        apb_xfer(1'b1, 8'h00, d, pop_at_done, rd, err, w);
        check_val("tx_waits", 32'(w), 32'(WS));
        check_val("tx_slverr", {31'd0, err}, {31'd0, ~accept});
        if (accept) sb_q.push_back(d);
    endtask

    task automatic drain_all();
        int guard = 0;
        out_ready = 1'b1;
        while (sb_q.size() != 0 && guard < 200) begin
            @(posedge PCLK); #1;
            guard++;
        end
        check_val("drain_model", 32'(sb_q.size()), 32'd0);
        out_ready = 1'b0;
        check_val("drain_valid", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        err;
        int          w;
        int          pops_snap;

        PRESERN = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = 8'h00; PWDATA = 32'd0; out_ready = 1'b0;
        #1;
        check_val("rst_pready", {31'd0, PREADY}, 32'd0);
        check_val("rst_pslverr", {31'd0, PSLVERR}, 32'd0);
        check_val("rst_prdata", PRDATA, 32'd0);
        check_val("rst_valid", {31'd0, out_valid}, 32'd0);
        check_val("rst_irq", {31'd0, irq}, 32'd0);
        repeat (2) @(posedge PCLK);
        #1 PRESERN = 1'b1;

        apb_xfer(1'b0, 8'h04, 32'd0, 1'b0, rd, err, w);
        check_val("status_reset", rd, 32'h0000_0001);
        check_val("status_rd_err", {31'd0, err}, 32'd0);
        check_val("status_rd_waits", 32'(w), 32'(WS));

        // Single word through the stream.
        wr_txdata(32'hCAFE_0001, 1'b0);
        reg_read(8'h04, rd);
        check_val("status_level1", rd, 32'h0000_0100);
        pops_snap = n_pops;
        out_ready = 1'b1;
        reg_write(8'h08, 32'h1);
        repeat (3) @(posedge PCLK);
        #1;
        check_val("one_pop", 32'(n_pops - pops_snap), 32'd1);
        check_val("stream_empty", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b0;

        // Fill to full, then overflow.
        reg_write(8'h08, 32'h0);
        for (int i = 0; i < DEPTH; i++) wr_txdata(32'hA000_0000 + 32'(i), 1'b0);
        reg_read(8'h04, rd);
        check_val("status_full", rd, 32'h0000_1002);
        wr_txdata(32'hDEAD_BEEF, 1'b0);
        reg_read(8'h04, rd);
        check_val("status_ovf", rd, 32'h0000_1006);
        check_val("head_held", out_data, sb_q[0]);
        reg_write(8'h04, 32'h4);
        reg_read(8'h04, rd);
        check_val("ovf_cleared", rd, 32'h0000_1002);

        // Push coinciding with a pop at full.
        reg_write(8'h08, 32'h1);
        wr_txdata(32'hB000_0016, 1'b1);
        reg_read(8'h04, rd);
        check_val("full_push_pop", rd, 32'h0000_1002);
        drain_all();

        // Threshold interrupt.
        reg_write(8'h0C, 32'h3);
        reg_read(8'h0C, rd);
        check_val("thresh_rd", rd, 32'h3);
        reg_write(8'h08, 32'h5);
        for (int i = 0; i < 5; i++) wr_txdata(32'hC000_0000 + 32'(i), 1'b0);
        @(posedge PCLK); #1;
        check_val("irq_lvl5", {31'd0, irq}, 32'd0);
        for (int p = 0; p < 2; p++) begin
            @(posedge PCLK); #1 out_ready = 1'b1;
            @(posedge PCLK); #1 out_ready = 1'b0;
        end
        check_val("irq_lag", {31'd0, irq}, 32'd0);
        @(posedge PCLK); #1;
        check_val("irq_rise", {31'd0, irq}, 32'd1);
        repeat (3) @(posedge PCLK);
        #1;
        check_val("irq_hold", {31'd0, irq}, 32'd1);
        wr_txdata(32'hC000_0010, 1'b0);
        check_val("irq_after_push", {31'd0, irq}, 32'd1);
        @(posedge PCLK); #1;
        check_val("irq_fall", {31'd0, irq}, 32'd0);

        // Flush with the stream ready.
        reg_write(8'h08, 32'h0);
        for (int i = 0; i < 4; i++) wr_txdata(32'hD000_0000 + 32'(i), 1'b0);
        reg_read(8'h04, rd);
        check_val("status_lvl8", rd, 32'h0000_0800);
        pops_snap = n_pops;
        out_ready = 1'b1;
        reg_write(8'h08, 32'h7);
        sb_q.delete();
        check_val("flush_valid", {31'd0, out_valid}, 32'd0);
        reg_read(8'h04, rd);
        check_val("flush_status", rd, 32'h0000_0009);
        reg_read(8'h08, rd);
        check_val("ctrl_rd", rd, 32'h0000_0005);
        check_val("flush_no_pop", 32'(n_pops - pops_snap), 32'd0);
        out_ready = 1'b0;

        // Reset in the middle of an access phase.
        wr_txdata(32'hE000_0001, 1'b0);
        wr_txdata(32'hE000_0002, 1'b0);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h00; PWDATA = 32'hE000_0003;
        @(posedge PCLK); #1 PENABLE = 1'b1;
        @(posedge PCLK); #1 PRESERN = 1'b0;
        #1;
        check_val("midrst_pready", {31'd0, PREADY}, 32'd0);
        check_val("midrst_valid", {31'd0, out_valid}, 32'd0);
        check_val("midrst_irq", {31'd0, irq}, 32'd0);
        sb_q.delete();
        m_enable = 1'b0;
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1 PRESERN = 1'b1;
        reg_read(8'h04, rd);
        check_val("postrst_status", rd, 32'h0000_0001);
        wr_txdata(32'h1234_5678, 1'b0);
        reg_read(8'h04, rd);
        check_val("postrst_level", rd, 32'h0000_0100);
        reg_write(8'h08, 32'h1);
        drain_all();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
